cpu_reg_ctrl: RTL and testbench

Multi-cycle instruction sequencer for the CPU register file and PC block. It drives the three 4-bit register selects, the PC enable and the register-bus/PC-bus source selects. It fetches each instruction over a request/acknowledge handshake and steps it through FETCH/DECODE/EXEC/MEM/WB. It sits between instruction/data memory and the register/ALU datapath.

---
 rtl/cpu_ctrl_pkg.sv | 64 ++++++
 rtl/cpu_ctrl_watchdog.sv | 42 ++++
 rtl/cpu_reg_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_cpu_reg_ctrl.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the CPU register/PC sequencer: opcodes, FSM states,
// bus-source and fault encodings, and instruction field positions.
package cpu_ctrl_pkg;

    // Opcodes (instruction bits [31:28])
    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_AND  = 4'h3;
    localparam logic [3:0] OP_OR   = 4'h4;
    localparam logic [3:0] OP_LDI  = 4'h5;
    localparam logic [3:0] OP_LD   = 4'h6;
    localparam logic [3:0] OP_ST   = 4'h7;
    localparam logic [3:0] OP_BEQ  = 4'h8;
    localparam logic [3:0] OP_JMP  = 4'h9;
    localparam logic [3:0] OP_HALT = 4'hF;

    // Sequencer states
    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALT,
        S_FAULT
    } state_e;

    // Register-bus source encodings
    localparam logic [1:0] BUS_ALU  = 2'd0;
    localparam logic [1:0] BUS_IMM  = 2'd1;
    localparam logic [1:0] BUS_DMEM = 2'd2;

    // Fault codes
    localparam logic [1:0] FLT_NONE    = 2'd0;
    localparam logic [1:0] FLT_ILLEGAL = 2'd1;
    localparam logic [1:0] FLT_TIMEOUT = 2'd2;

    // Instruction field bit positions
    localparam int OP_MSB  = 31;
    localparam int OP_LSB  = 28;
    localparam int RD_MSB  = 27;
    localparam int RD_LSB  = 24;
    localparam int RS1_MSB = 23;
    localparam int RS1_LSB = 20;
    localparam int RS2_MSB = 19;
    localparam int RS2_LSB = 16;
    localparam int IMM_MSB = 15;
    localparam int IMM_LSB = 0;

    // Watchdog counter width
    localparam int WDOG_W = 8;

    // Opcodes whose ALU operation is passed straight to the datapath
    function automatic logic is_alu_op(input logic [3:0] op);
        return (op >= OP_ADD) && (op <= OP_OR);
    endfunction

    // Opcodes A..E have no defined meaning
    function automatic logic is_illegal_op(input logic [3:0] op);
        return (op >= 4'hA) && (op <= 4'hE);
    endfunction

endpackage

// File: rtl/cpu_ctrl_watchdog.sv
// Memory-acknowledge watchdog: counts consecutive waiting cycles and flags
// expiry on the cycle whose count would reach TIMEOUT. TIMEOUT=0 disables it.
module cpu_ctrl_watchdog
    import cpu_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam logic [WDOG_W-1:0] LAST = WDOG_W'(TIMEOUT - 1);

    logic [WDOG_W-1:0] cnt_q;
    logic [WDOG_W-1:0] cnt_d;

    // Next count: clear has priority over counting
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + WDOG_W'(1);
        end
    end

    // Counter register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Expire in the waiting cycle that completes TIMEOUT waiting cycles
    assign expired_o = (TIMEOUT != 0) && en_i && (cnt_q == LAST);

endmodule

// File: rtl/cpu_reg_ctrl.sv
// Multi-cycle instruction sequencer driving register selects, PC load and
// bus-source selects. Steps each instruction through FETCH/DECODE/EXEC/MEM/WB
// with request/acknowledge handshakes to instruction and data memory.
module cpu_reg_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT  = 255,
    parameter logic [3:0]  NOWR_IDX = 4'd15
) (
    input  logic        CLK,
    input  logic        CLR,
    output logic        IMEM_REQ,
    input  logic        IMEM_ACK,
    input  logic [31:0] IMEM_DATA,
    output logic        DMEM_REQ,
    output logic        DMEM_WE,
    input  logic        DMEM_ACK,
    input  logic        ZERO,
    output logic [3:0]  REG_1_SEL,
    output logic [3:0]  REG_2_SEL,
    output logic [3:0]  REG_SEL,
    output logic        PC_EN,
    output logic        PC_SRC,
    output logic [1:0]  BUS_SRC,
    output logic [3:0]  ALU_OP,
    output logic [15:0] IMM,
    output logic        HALTED,
    output logic [1:0]  FAULT
);

    state_e      state_q, state_d;
    logic [31:0] ir_q, ir_d;
    logic [1:0]  fault_q, fault_d;
    // Low for the first cycle after reset so no request is visible while
    // reset is (or has just been) asserted.
    logic        live_q;

    logic [3:0]  op;
    logic [3:0]  rd;
    logic        fetch_active;
    logic        wd_en;
    logic        wd_clr;
    logic        wd_expired;

    assign op = ir_q[OP_MSB:OP_LSB];
    assign rd = ir_q[RD_MSB:RD_LSB];

    assign REG_1_SEL = ir_q[RS1_MSB:RS1_LSB];
    assign REG_2_SEL = ir_q[RS2_MSB:RS2_LSB];
    assign IMM       = ir_q[IMM_MSB:IMM_LSB];
    assign HALTED    = (state_q == S_HALT) || (state_q == S_FAULT);
    assign FAULT     = fault_q;

    // Watchdog runs while a request is outstanding and clears on its ACK;
    // an ACK without a request is not a handshake.
    assign fetch_active = (state_q == S_FETCH) && live_q;
    assign wd_en  = (fetch_active && !IMEM_ACK) || ((state_q == S_MEM) && !DMEM_ACK);
    assign wd_clr = (fetch_active &&  IMEM_ACK) || ((state_q == S_MEM) &&  DMEM_ACK);

    cpu_ctrl_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk_i     (CLK),
        .rst_ni    (CLR),
        .clr_i     (wd_clr),
        .en_i      (wd_en),
        .expired_o (wd_expired)
    );

    // Next-state and output decode
    always_comb begin
        // NOTE: every output and next-state value gets a default first, so no
        // path through the case statement can leave one unassigned (no latches).
        state_d  = state_q;
        ir_d     = ir_q;
        fault_d  = fault_q;
        IMEM_REQ = 1'b0;
        DMEM_REQ = 1'b0;
        DMEM_WE  = 1'b0;
        REG_SEL  = NOWR_IDX;
        PC_EN    = 1'b0;
        PC_SRC   = 1'b0;
        BUS_SRC  = BUS_ALU;
        ALU_OP   = 4'd0;

        unique case (state_q)
            S_FETCH: begin
                IMEM_REQ = live_q;
                if (fetch_active && IMEM_ACK) begin
                    ir_d    = IMEM_DATA;
                    state_d = S_DECODE;
                end else if (wd_expired) begin
                    fault_d = FLT_TIMEOUT;
                    state_d = S_FAULT;
                end
            end

            S_DECODE: begin
                if (op == OP_HALT) begin
                    state_d = S_HALT;
                end else if (is_illegal_op(op)) begin
                    fault_d = FLT_ILLEGAL;
                    state_d = S_FAULT;
                end else begin
                    state_d = S_EXEC;
                end
            end

            S_EXEC: begin
                ALU_OP = is_alu_op(op) ? op : 4'd0;
                case (op)
                    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_LDI: state_d = S_WB;
                    OP_LD, OP_ST:                         state_d = S_MEM;
                    OP_BEQ: begin
                        PC_EN   = 1'b1;
                        PC_SRC  = ZERO;
                        state_d = S_FETCH;
                    end
                    OP_JMP: begin
                        PC_EN   = 1'b1;
                        PC_SRC  = 1'b1;
                        state_d = S_FETCH;
                    end
                    default: begin
                        // NOP retires here with a sequential PC update
                        PC_EN   = 1'b1;
                        state_d = S_FETCH;
                    end
                endcase
            end

            S_MEM: begin
                DMEM_REQ = 1'b1;
                DMEM_WE  = (op == OP_ST);
                if (DMEM_ACK) begin
                    if (op == OP_ST) begin
                        PC_EN   = 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end else if (wd_expired) begin
                    fault_d = FLT_TIMEOUT;
                    state_d = S_FAULT;
                end
            end

            S_WB: begin
                // ALU op stays valid so its result is still on the bus
                ALU_OP  = is_alu_op(op) ? op : 4'd0;
                REG_SEL = rd;
                PC_EN   = 1'b1;
                state_d = S_FETCH;
                if (op == OP_LDI) begin
                    BUS_SRC = BUS_IMM;
                end else if (op == OP_LD) begin
                    BUS_SRC = BUS_DMEM;
                end else begin
                    BUS_SRC = BUS_ALU;
                end
            end

            S_HALT, S_FAULT: begin
                // Absorbing until reset; all strobes stay at their defaults
            end

            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    // State, instruction and fault registers
    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            // NOTE: sequential state uses non-blocking assignments only, so
            // every register samples the values from before this clock edge.
            state_q <= S_FETCH;
            ir_q    <= '0;
            fault_q <= FLT_NONE;
            live_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            fault_q <= fault_d;
            live_q  <= 1'b1;
        end
    end

endmodule

// File: tb/tb_cpu_reg_ctrl.sv
// Directed bench for cpu_reg_ctrl: walks hand-built instructions through the
// sequencer and compares every strobe against hand-computed values.
module tb_cpu_reg_ctrl;

    logic        CLK = 1'b0;
    logic        CLR;
    logic        IMEM_REQ;
    logic        IMEM_ACK;
    logic [31:0] IMEM_DATA;
    logic        DMEM_REQ;
    logic        DMEM_WE;
    logic        DMEM_ACK;
    logic        ZERO;
    logic [3:0]  REG_1_SEL;
    logic [3:0]  REG_2_SEL;
    logic [3:0]  REG_SEL;
    logic        PC_EN;
    logic        PC_SRC;
    logic [1:0]  BUS_SRC;
    logic [3:0]  ALU_OP;
    logic [15:0] IMM;
    logic        HALTED;
    logic [1:0]  FAULT;

    int checks   = 0;
    int failures = 0;

    cpu_reg_ctrl dut (
        .CLK       (CLK),
        .CLR       (CLR),
        .IMEM_REQ  (IMEM_REQ),
        .IMEM_ACK  (IMEM_ACK),
        .IMEM_DATA (IMEM_DATA),
        .DMEM_REQ  (DMEM_REQ),
        .DMEM_WE   (DMEM_WE),
        .DMEM_ACK  (DMEM_ACK),
        .ZERO      (ZERO),
        .REG_1_SEL (REG_1_SEL),
        .REG_2_SEL (REG_2_SEL),
        .REG_SEL   (REG_SEL),
        .PC_EN     (PC_EN),
        .PC_SRC    (PC_SRC),
        .BUS_SRC   (BUS_SRC),
        .ALU_OP    (ALU_OP),
        .IMM       (IMM),
        .HALTED    (HALTED),
        .FAULT     (FAULT)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv)
        else begin
            failures++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    // Advance to 2 time units after the next rising edge
    task automatic tick();
        @(posedge CLK);
        #2;
    endtask

    // Present an instruction with same-cycle ACK; returns settled in DECODE
    task automatic fetch(input logic [31:0] ins);
        IMEM_DATA = ins;
        IMEM_ACK  = 1'b1;
        #1;
        check("fetch_req", IMEM_REQ, 1);
        tick();
        IMEM_ACK  = 1'b0;
        IMEM_DATA = '0;
        #1;
        check("decode_req_low", IMEM_REQ, 0);
    endtask

    // Pulse reset away from the clock edge; returns in the first live FETCH cycle
    task automatic do_reset();
        CLR = 1'b0;
        #1;
        check("rst_halted", HALTED, 0);
        check("rst_fault", FAULT, 0);
        check("rst_req", IMEM_REQ, 0);
        @(negedge CLK);
        CLR = 1'b1;
        tick();
        check("rst_live_req", IMEM_REQ, 1);
    endtask

    int n_req;

    initial begin
        CLR       = 1'b0;
        IMEM_ACK  = 1'b0;
        IMEM_DATA = '0;
        DMEM_ACK  = 1'b0;
        ZERO      = 1'b0;

        // ---- reset values ----
        #3;
        check("reset_imem_req", IMEM_REQ, 0);
        check("reset_dmem_req", DMEM_REQ, 0);
        check("reset_pc_en", PC_EN, 0);
        check("reset_reg_sel", REG_SEL, 15);
        check("reset_reg1", REG_1_SEL, 0);
        check("reset_reg2", REG_2_SEL, 0);
        check("reset_imm", IMM, 0);
        check("reset_alu_op", ALU_OP, 0);
        check("reset_halted", HALTED, 0);
        check("reset_fault", FAULT, 0);

        // ACK offered before any request must not load an instruction
        IMEM_ACK  = 1'b1;
        IMEM_DATA = 32'h1FF0_0000;
        @(negedge CLK);
        CLR = 1'b1;
        #1;
        check("release_req_low", IMEM_REQ, 0);
        tick();
        IMEM_ACK  = 1'b0;
        IMEM_DATA = '0;
        #1;
        check("first_clk_req", IMEM_REQ, 1);
        check("first_clk_pc_en", PC_EN, 0);
        check("ack_without_req", REG_1_SEL, 0);

        // ---- ADD r3,r1,r2 ----
        fetch(32'h1312_0000);
        check("add_rs1", REG_1_SEL, 1);
        check("add_rs2", REG_2_SEL, 2);
        check("add_dec_regsel", REG_SEL, 15);
        tick();
        check("add_alu_op", ALU_OP, 1);
        check("add_exec_regsel", REG_SEL, 15);
        check("add_exec_pc_en", PC_EN, 0);
        tick();
        check("add_wb_regsel", REG_SEL, 3);
        check("add_wb_bus", BUS_SRC, 0);
        check("add_wb_pc_en", PC_EN, 1);
        check("add_wb_pc_src", PC_SRC, 0);
        tick();
        check("add_next_req", IMEM_REQ, 1);
        check("add_next_pc_en", PC_EN, 0);
        check("add_next_regsel", REG_SEL, 15);

        // ---- LD r4 with DMEM_ACK delayed 3 cycles ----
        fetch(32'h6450_0000);
        tick();
        check("ld_exec_dreq", DMEM_REQ, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("ld_wait_dreq", DMEM_REQ, 1);
            check("ld_wait_we", DMEM_WE, 0);
            check("ld_wait_pc_en", PC_EN, 0);
        end
        tick();
        DMEM_ACK = 1'b1;
        #1;
        check("ld_ack_dreq", DMEM_REQ, 1);
        check("ld_ack_pc_en", PC_EN, 0);
        tick();
        DMEM_ACK = 1'b0;
        #1;
        check("ld_wb_dreq", DMEM_REQ, 0);
        check("ld_wb_regsel", REG_SEL, 4);
        check("ld_wb_bus", BUS_SRC, 2);
        check("ld_wb_pc_en", PC_EN, 1);
        tick();
        check("ld_next_pc_en", PC_EN, 0);
        check("ld_next_regsel", REG_SEL, 15);

        // ---- ST, zero-wait ----
        fetch(32'h7012_0000);
        tick();
        tick();
        DMEM_ACK = 1'b1;
        #1;
        check("st_dreq", DMEM_REQ, 1);
        check("st_we", DMEM_WE, 1);
        check("st_pc_en", PC_EN, 1);
        check("st_regsel", REG_SEL, 15);
        tick();
        DMEM_ACK = 1'b0;
        #1;
        check("st_next_req", IMEM_REQ, 1);
        check("st_next_pc_en", PC_EN, 0);

        // ---- LDI r7, 0xABCD ----
        fetch(32'h5700_ABCD);
        check("ldi_imm", IMM, 16'hABCD);
        tick();
        check("ldi_exec_alu_op", ALU_OP, 0);
        tick();
        check("ldi_wb_regsel", REG_SEL, 7);
        check("ldi_wb_bus", BUS_SRC, 1);
        check("ldi_wb_pc_en", PC_EN, 1);
        tick();

        // ---- BEQ taken ----
        fetch(32'h8012_0010);
        tick();
        ZERO = 1'b1;
        #1;
        check("beq_t_pc_en", PC_EN, 1);
        check("beq_t_pc_src", PC_SRC, 1);
        check("beq_t_regsel", REG_SEL, 15);
        tick();
        ZERO = 1'b0;
        #1;
        check("beq_t_next_pc_en", PC_EN, 0);
        check("beq_t_next_regsel", REG_SEL, 15);

        // ---- BEQ not taken ----
        fetch(32'h8012_0010);
        tick();
        check("beq_nt_pc_en", PC_EN, 1);
        check("beq_nt_pc_src", PC_SRC, 0);
        check("beq_nt_regsel", REG_SEL, 15);
        tick();
        check("beq_nt_next_regsel", REG_SEL, 15);

        // ---- JMP ----
        fetch(32'h9000_0000);
        tick();
        check("jmp_pc_en", PC_EN, 1);
        check("jmp_pc_src", PC_SRC, 1);
        tick();
        check("jmp_next_pc_en", PC_EN, 0);

        // ---- reset asserted mid-MEM ----
        fetch(32'h6450_0000);
        tick();
        tick();
        check("mr_dreq", DMEM_REQ, 1);
        CLR = 1'b0;
        #1;
        check("mr_async_dreq", DMEM_REQ, 0);
        check("mr_async_ireq", IMEM_REQ, 0);
        check("mr_async_pc_en", PC_EN, 0);
        check("mr_async_regsel", REG_SEL, 15);
        check("mr_async_reg1", REG_1_SEL, 0);
        check("mr_async_imm", IMM, 0);
        tick();
        check("mr_held_ireq", IMEM_REQ, 0);
        @(negedge CLK);
        CLR = 1'b1;
        #1;
        check("mr_release_ireq", IMEM_REQ, 0);
        tick();
        check("mr_first_clk_ireq", IMEM_REQ, 1);
        check("mr_first_clk_pc_en", PC_EN, 0);

        // ---- illegal opcode 0xB ----
        fetch(32'hB000_0000);
        check("ill_decode_halted", HALTED, 0);
        tick();
        check("ill_halted", HALTED, 1);
        check("ill_fault", FAULT, 1);
        IMEM_ACK = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            check("ill_absorb", {IMEM_REQ, DMEM_REQ, PC_EN, HALTED}, 4'b0001);
        end
        IMEM_ACK = 1'b0;
        do_reset();

        // ---- HALT ----
        fetch(32'hF000_0000);
        tick();
        check("halt_halted", HALTED, 1);
        check("halt_fault", FAULT, 0);
        IMEM_ACK = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            check("halt_absorb", {IMEM_REQ, DMEM_REQ, PC_EN, HALTED}, 4'b0001);
        end
        IMEM_ACK = 1'b0;
        do_reset();

        // ---- fetch timeout: REQ held exactly 255 cycles, then FAULT=2 ----
        n_req = 0;
        for (int i = 0; i < 400; i++) begin
            if (IMEM_REQ !== 1'b1) break;
            n_req++;
            tick();
        end
        check("wd_req_cycles", n_req, 255);
        check("wd_fault", FAULT, 2);
        check("wd_halted", HALTED, 1);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("wd_req_after", IMEM_REQ, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global time limit so the run always ends
    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "time limit reached");
    end

endmodule
